// File: rtl/packet_loader.sv
// rtl/packet_loader.sv - UART boot loader: parses LOAD/RUN frames, writes RAM, releases CPU reset
//
// Purpose: receives framed bytes from a UART receiver, writes LOAD payload words
// into RAM, answers each frame with ACK/NAK, and releases the CPU from reset
// after an acknowledged RUN frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_data, rx_done  received byte and its one-cycle strobe
//   tx_data, transmit byte to send and its one-cycle start strobe
//   tx_done           transmission-complete strobe
//   ram_addr, ram_data, ram_we   RAM word write port
//   trigger           re-enter boot mode (highest priority)
//   booting, cpu_rst  boot-mode flag and CPU reset (active-high)
//   err               sticky error flag (NAK or timeout)
module packet_loader #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 1,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [7:0]              tx_data,
  output logic                    transmit,
  input  logic                    tx_done,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [8*WORD_BYTES-1:0] ram_data,
  output logic                    ram_we,
  input  logic                    trigger,
  output logic                    booting,
  output logic                    cpu_rst,
  output logic                    err
);

  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [7:0]  CMD_LOAD  = 8'h01;
  localparam logic [7:0]  CMD_RUN   = 8'h02;
  localparam logic [7:0]  ACK       = 8'h06;
  localparam logic [7:0]  NAK       = 8'h15;
  localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L,
    S_DATA, S_CSUM, S_REPLY, S_WAIT_TX, S_RUN
  } state_e;

  state_e                  state_q, state_d;
  logic                    is_load_q, is_load_d;
  logic [7:0]              hi_q, hi_d;        // holds ADDR_H / LEN_H until the low byte arrives
  logic [15:0]             len_q, len_d;      // words still to receive
  logic [1:0]              bcnt_q, bcnt_d;    // byte lane within the current word
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [8*WORD_BYTES-1:0] data_q, data_d;
  logic                    we_q, we_d;
  logic [7:0]              sum_q, sum_d;
  logic                    good_q, good_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    transmit_q, transmit_d;
  logic                    booting_q, booting_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    err_q, err_d;
  logic [31:0]             tmo_q, tmo_d;

  logic [15:0] word16;
  logic [7:0]  csum_total;
  logic        in_frame;

  assign word16     = {hi_q, rx_data};
  assign csum_total = sum_q + rx_data;
  assign in_frame   = (state_q >= S_CMD) && (state_q <= S_CSUM);

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    hi_d       = hi_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = 1'b0;
    sum_d      = sum_q;
    good_d     = good_q;
    tx_data_d  = tx_data_q;
    transmit_d = 1'b0;
    booting_d  = booting_q;
    cpu_rst_d  = cpu_rst_q;
    err_d      = err_q;
    tmo_d      = tmo_q;

    // Address advances at the end of the write-strobe cycle so the strobe sees it stable.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (trigger) begin
      state_d   = S_IDLE;
      booting_d = 1'b1;
      cpu_rst_d = 1'b1;
      err_d     = 1'b0;
      sum_d     = 8'd0;
      tmo_d     = 32'd0;
      bcnt_d    = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tmo_d = 32'd0;
          if (rx_done && rx_data == SYNC) begin
            sum_d   = 8'd0;
            state_d = S_CMD;
          end
        end
        S_CMD: if (rx_done) begin
          if (rx_data == CMD_LOAD || rx_data == CMD_RUN) begin
            is_load_d = (rx_data == CMD_LOAD);
            sum_d     = rx_data;
            state_d   = S_ADDR_H;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR_H: if (rx_done) begin
          hi_d    = rx_data;
          sum_d   = csum_total;
          state_d = S_ADDR_L;
        end
        S_ADDR_L: if (rx_done) begin
          addr_d  = word16[ADDR_W-1:0];
          sum_d   = csum_total;
          state_d = S_LEN_H;
        end
        S_LEN_H: if (rx_done) begin
          hi_d    = rx_data;
          sum_d   = csum_total;
          state_d = S_LEN_L;
        end
        S_LEN_L: if (rx_done) begin
          len_d   = word16;
          bcnt_d  = 2'd0;
          sum_d   = csum_total;
          state_d = (word16 == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (rx_done) begin
          sum_d = csum_total;
          if (is_load_q) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (bcnt_q == 2'(i)) data_d[8*i +: 8] = rx_data;
            end
          end
          if (bcnt_q == LAST_BYTE) begin
            bcnt_d = 2'd0;
            we_d   = is_load_q;
            len_d  = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_CSUM;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
        S_CSUM: if (rx_done) begin
          good_d  = (csum_total == 8'd0);
          state_d = S_REPLY;
        end
        S_REPLY: begin
          transmit_d = 1'b1;
          tx_data_d  = good_q ? ACK : NAK;
          if (!good_q) err_d = 1'b1;
          state_d = S_WAIT_TX;
        end
        S_WAIT_TX: if (tx_done) begin
          if (good_q && !is_load_q) begin
            booting_d = 1'b0;
            cpu_rst_d = 1'b0;
            state_d   = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: ;  // CPU owns the system; only trigger leaves this state
        default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog: any received byte rearms it, silence for TIMEOUT cycles aborts.
      if (in_frame) begin
        if (rx_done) begin
          tmo_d = 32'd0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = 32'd0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      is_load_q  <= 1'b0;
      hi_q       <= 8'd0;
      len_q      <= 16'd0;
      bcnt_q     <= 2'd0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      sum_q      <= 8'd0;
      good_q     <= 1'b0;
      tx_data_q  <= 8'd0;
      transmit_q <= 1'b0;
      booting_q  <= 1'b1;
      cpu_rst_q  <= 1'b1;
      err_q      <= 1'b0;
      tmo_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      hi_q       <= hi_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
      sum_q      <= sum_d;
      good_q     <= good_d;
      tx_data_q  <= tx_data_d;
      transmit_q <= transmit_d;
      booting_q  <= booting_d;
      cpu_rst_q  <= cpu_rst_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign transmit = transmit_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_we   = we_q;
  assign booting  = booting_q;
  assign cpu_rst  = cpu_rst_q;
  assign err      = err_q;

endmodule

// File: tb/tb_packet_loader.sv
// tb/tb_packet_loader.sv - directed bench for packet_loader (byte and 16-bit word variants)
module tb_packet_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx_done, tx_done, trigger;
  logic [7:0] rx_data;

  logic [7:0]  tx_data1, tx_data2;
  logic        transmit1, transmit2, ram_we1, ram_we2;
  logic [15:0] ram_addr1, ram_addr2;
  logic [7:0]  ram_data1;
  logic [15:0] ram_data2;
  logic        booting1, booting2, cpu_rst1, cpu_rst2, err1, err2;

  packet_loader #(.ADDR_W(16), .WORD_BYTES(1), .TIMEOUT(100)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data1), .transmit(transmit1), .tx_done(tx_done),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_we(ram_we1),
    .trigger(trigger), .booting(booting1), .cpu_rst(cpu_rst1), .err(err1)
  );

  packet_loader #(.ADDR_W(16), .WORD_BYTES(2), .TIMEOUT(100)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data2), .transmit(transmit2), .tx_done(tx_done),
    .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_we(ram_we2),
    .trigger(trigger), .booting(booting2), .cpu_rst(cpu_rst2), .err(err2)
  );

  logic [31:0] wr1[$], wr2[$];
  logic [7:0]  tx1[$], tx2[$];
  logic [7:0]  frame_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Every strobe cycle is logged, so a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (ram_we1)   wr1.push_back({ram_addr1, 8'h00, ram_data1});
    if (ram_we2)   wr2.push_back({ram_addr2, ram_data2});
    if (transmit1) tx1.push_back(tx_data1);
    if (transmit2) tx2.push_back(tx_data2);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_q();
    foreach (frame_q[i]) send(frame_q[i]);
  endtask

  task automatic clear_logs();
    wr1.delete(); wr2.delete(); tx1.delete(); tx2.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trigger = 1'b0; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_logs();
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
  endtask

  task automatic get_reply(input int which, input logic [7:0] exp, input string tag);
    int k = 0;
    while (((which == 1) ? tx1.size() : tx2.size()) == 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (((which == 1) ? tx1.size() : tx2.size()) == 0)
      check({tag, "_no_transmit"}, 32'h1FF, {24'h0, exp});
    else if (which == 1)
      check(tag, {24'h0, tx1.pop_front()}, {24'h0, exp});
    else
      check(tag, {24'h0, tx2.pop_front()}, {24'h0, exp});
  endtask

  task automatic tx_ack();
    idle(3);
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; rx_done = 1'b0; tx_done = 1'b0; rx_data = 8'h00;
    #12;
    check("rst_booting",  {31'h0, booting1},  32'h1);
    check("rst_cpu_rst",  {31'h0, cpu_rst1},  32'h1);
    check("rst_err",      {31'h0, err1},      32'h0);
    check("rst_transmit", {31'h0, transmit1}, 32'h0);
    check("rst_ram_we",   {31'h0, ram_we1},   32'h0);
    check("rst_tx_data",  {24'h0, tx_data1},  32'h0);
    check("rst_ram_addr", {16'h0, ram_addr1}, 32'h0);
    check("rst_ram_data", {16'h0, ram_data2}, 32'h0);
    do_reset();

    // Noise byte before sync, then a two-byte LOAD at 0x0010 (sum 0x78, csum 0x88).
    send(8'h00);
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h88};
    send_q();
    idle(3);
    check("load_wr_count", wr1.size(), 32'd2);
    check("load_wr0", wr1[0], {16'h0010, 16'h00AA});
    check("load_wr1", wr1[1], {16'h0011, 16'h00BB});
    get_reply(1, 8'h06, "load_ack");
    tx_ack();
    check("load_err", {31'h0, err1}, 32'h0);
    check("load_cpu_rst", {31'h0, cpu_rst1}, 32'h1);

    // Unknown command: silently back to IDLE.
    clear_logs();
    frame_q = '{8'hA5, 8'h03};
    send_q();
    idle(20);
    check("badcmd_no_tx", tx1.size(), 32'd0);
    check("badcmd_no_err", {31'h0, err1}, 32'h0);

    // Checksum off by one: writes stay, NAK, err sticky, CPU held.
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h89};
    send_q();
    idle(3);
    check("nak_wr_kept", wr1.size(), 32'd2);
    get_reply(1, 8'h15, "nak_reply");
    tx_ack();
    check("nak_err", {31'h0, err1}, 32'h1);
    check("nak_cpu_rst", {31'h0, cpu_rst1}, 32'h1);
    pulse_trigger();
    check("trig_clears_err", {31'h0, err1}, 32'h0);

    // Trigger coinciding with the last payload byte aborts the write and reply.
    clear_logs();
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h00, 8'h02, 8'hAA};
    send_q();
    @(posedge clk); #1;
    rx_data = 8'hBB; rx_done = 1'b1; trigger = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0; trigger = 1'b0;
    idle(20);
    check("abort_wr_count", wr1.size(), 32'd1);
    check("abort_wr0", wr1[0], {16'h0020, 16'h00AA});
    check("abort_no_tx", tx1.size(), 32'd0);

    // RUN frame with LEN=0 releases the CPU on tx_done.
    frame_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE};
    send_q();
    get_reply(1, 8'h06, "run_ack");
    check("run_cpu_rst_before", {31'h0, cpu_rst1}, 32'h1);
    tx_ack();
    check("run_cpu_rst_after", {31'h0, cpu_rst1}, 32'h0);
    check("run_booting_after", {31'h0, booting1}, 32'h0);
    clear_logs();
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h88};
    send_q();
    idle(10);
    check("run_ignores_rx_wr", wr1.size(), 32'd0);
    check("run_ignores_rx_tx", tx1.size(), 32'd0);
    pulse_trigger();
    check("retrig_cpu_rst", {31'h0, cpu_rst1}, 32'h1);
    check("retrig_booting", {31'h0, booting1}, 32'h1);

    // 16-bit words, address wraps from 0xFFFF (sum 0xAB, csum 0x55).
    do_reset();
    frame_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_q();
    idle(3);
    check("wb2_wr_count", wr2.size(), 32'd2);
    check("wb2_wr0", wr2[0], {16'hFFFF, 16'h2211});
    check("wb2_wr1", wr2[1], {16'h0000, 16'h4433});
    get_reply(2, 8'h06, "wb2_ack");
    tx_ack();

    // Stall after ADDR_L: err rises exactly 100 cycles after the last byte.
    do_reset();
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10};
    send_q();
    idle(99);
    check("tmo_err_early", {31'h0, err1}, 32'h0);
    idle(1);
    check("tmo_err_set", {31'h0, err1}, 32'h1);
    check("tmo_no_tx", tx1.size(), 32'd0);
    frame_q = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h88};
    send_q();
    get_reply(1, 8'h06, "tmo_next_ack");
    tx_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_loader.md
PACKET_LOADER -- requirements
Module: packet_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM word-address width, legal range 1..16.
REQ-002 SHALL have parameter WORD_BYTES, default 1, bytes per RAM word, legal range 1..4.
REQ-003 SHALL have parameter TIMEOUT, default 1000000, maximum idle cycles between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock; every register changes on its rising edge only.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8 bits: received UART byte, valid while rx_done=1.
REQ-007 SHALL have port rx_done, input, 1 bit: one-cycle pulse marking a new received byte.
REQ-008 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-009 SHALL have port transmit, output, 1 bit: one-cycle pulse that starts a UART transmission.
REQ-010 SHALL have port tx_done, input, 1 bit: one-cycle pulse marking transmission complete.
REQ-011 SHALL have port ram_addr, output, ADDR_W bits: RAM word address.
REQ-012 SHALL have port ram_data, output, 8*WORD_BYTES bits: RAM write data.
REQ-013 SHALL have port ram_we, output, 1 bit: one-cycle RAM write strobe.
REQ-014 SHALL have port trigger, input, 1 bit: request to re-enter boot mode.
REQ-015 SHALL have port booting, output, 1 bit: high while in boot mode.
REQ-016 SHALL have port cpu_rst, output, 1 bit: CPU reset, active-high.
REQ-017 SHALL have port err, output, 1 bit: sticky error flag, set by a NAK or a timeout.

Function
REQ-018 SHALL accept this frame format: SYNC(0xA5), CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN*WORD_BYTES payload bytes, then CSUM.
REQ-019 SHALL advance exactly one frame-parse state per rx_done pulse, in the order IDLE, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CSUM, REPLY, WAIT_TX.
REQ-020 SHALL stay in IDLE on any received byte other than 0xA5.
REQ-021 SHALL return to IDLE if CMD is not 0x01 (LOAD) or 0x02 (RUN), with no reply sent and no error flagged.
REQ-022 SHALL use the address as a word address, taking its lower ADDR_W bits, and SHALL treat LEN as a word count, where LEN=0 goes straight from LEN_L to CSUM.
REQ-023 SHALL assemble each word from payload bytes little-endian, so the first byte received lands in ram_data[7:0].
REQ-024 SHALL, in DATA with CMD=LOAD, pulse ram_we for one cycle in the cycle after the final byte of each word, holding ram_addr and ram_data stable during that cycle.
REQ-025 SHALL increment ram_addr after each write, wrapping modulo 2^ADDR_W.
REQ-026 SHALL, with CMD=RUN, receive and discard the payload bytes and never assert ram_we.
REQ-027 SHALL keep an 8-bit running sum of CMD, address, length and payload bytes; the frame is good iff (sum + CSUM) mod 256 = 0.
REQ-028 SHALL, in REPLY, set tx_data to 0x06 (ACK) for a good frame or 0x15 (NAK) for a bad one, pulse transmit for one cycle, then wait in WAIT_TX for tx_done.
REQ-029 SHALL set err on a NAK and leave it set until reset or trigger.
REQ-030 SHALL NOT roll back RAM writes already made by a NAKed LOAD frame.
REQ-031 SHALL, on tx_done after an ACKed RUN frame, clear cpu_rst and booting in the same cycle, then ignore all rx_done pulses until trigger.
REQ-032 SHALL, on tx_done in every other case, return to IDLE.
REQ-033 SHALL reload the timeout counter on every rx_done in states CMD through CSUM.
REQ-034 SHALL, if that counter reaches TIMEOUT, go to IDLE and set err without sending a reply.
REQ-035 SHALL ignore rx_done pulses while in REPLY or WAIT_TX.
REQ-036 SHALL give trigger priority over every other event: set booting=1 and cpu_rst=1, clear err, and abort to IDLE in the next cycle, with no reply and no write.

Reset
REQ-037 SHALL, with rst_n=0, force state=IDLE, booting=1, cpu_rst=1, err=0, transmit=0, ram_we=0, tx_data=0, ram_addr=0, ram_data=0, and clear the checksum and timeout counters.
REQ-038 SHALL treat assertion of rst_n mid-frame exactly as REQ-037, with no partial write completing.

Verification
REQ-039 SHALL be verified by this scenario: WORD_BYTES=1, frame A5 01 00 10 00 02 AA BB with correct CSUM -> ram_we pulses at address 0x0010 with data 0xAA and at 0x0011 with 0xBB, then ACK 0x06 is transmitted.
REQ-040 SHALL be verified by this scenario: WORD_BYTES=2, LOAD to address 0xFFFF, LEN=2, payload 11 22 33 44 -> writes 0x2211 at 0xFFFF and 0x4433 at 0x0000.
REQ-041 SHALL be verified by this scenario: correct frame with CSUM off by 1 -> NAK 0x15 is transmitted, err=1, and cpu_rst stays 1.
REQ-042 SHALL be verified by this scenario: ACKed RUN frame A5 02 00 00 00 00 FE -> cpu_rst and booting fall on tx_done, and a later trigger raises both again.
REQ-043 SHALL be verified by this scenario: TIMEOUT=100, stop after ADDR_L -> state returns to IDLE at cycle 100 with err=1, and a following good frame is ACKed.
REQ-044 SHALL be verified by this scenario: trigger in the same cycle as the final payload rx_done -> no ram_we, no transmit, state is IDLE.
